// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width default,
// scheduler state encoding and the byte-source identifiers used by the arbiter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_HOLD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_t;

  typedef enum logic {
    SRC_ECHO,
    SRC_RSP
  } src_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  rd_data,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is tracked by count alone,
  // so clearing the array would cost flops without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates uart_tx between buffered RX echo bytes and BDC response bytes,
// launching each byte with a tx_start pulse aligned to the TX baud tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int FIFO_AW  = 3,
  parameter int BUSY_TMO = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rsp_valid,
  input  logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_ready,
  input  logic               txclk_tick,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [DATA_W-1:0]  tx_data,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               tx_timeout
);

  localparam int                 TMO_W    = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(BUSY_TMO - 1);

  tx_state_t          state, state_nx;
  src_t               last_grant, last_grant_nx;
  logic [DATA_W-1:0]  tx_data_nx;
  logic               tx_start_nx;
  logic               busy_seen, busy_seen_nx;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nx;
  logic               timeout_set;

  logic [DATA_W-1:0]  fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant_ok;
  logic               pick_echo;
  logic               grant_echo;
  logic               grant_rsp;

  sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_valid),
    .wr_data (rx_data),
    .pop     (grant_echo),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Round-robin: with both sources pending, the one not granted last wins.
  assign grant_ok   = (state == ST_IDLE) && !tx_busy && (!fifo_empty || rsp_valid);
  assign pick_echo  = !fifo_empty && (!rsp_valid || last_grant == SRC_RSP);
  assign grant_echo = grant_ok && pick_echo;
  assign grant_rsp  = grant_ok && !pick_echo;
  assign rsp_ready  = grant_rsp && !reset;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    tx_data_nx    = tx_data;
    tx_start_nx   = tx_start;
    busy_seen_nx  = busy_seen;
    tmo_cnt_nx    = tmo_cnt;
    timeout_set   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (grant_ok) begin
          tx_data_nx    = grant_echo ? fifo_rd_data : rsp_data;
          last_grant_nx = grant_echo ? SRC_ECHO : SRC_RSP;
          state_nx      = ST_ARM;
        end
      end
      ST_ARM: begin
        if (txclk_tick) begin
          tx_start_nx  = 1'b1;
          busy_seen_nx = 1'b0;
          state_nx     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tx_busy) busy_seen_nx = 1'b1;
        if (txclk_tick) begin
          tx_start_nx = 1'b0;
          tmo_cnt_nx  = '0;
          state_nx    = (busy_seen || tx_busy) ? ST_WAIT_DONE : ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = ST_WAIT_DONE;
        end else if (txclk_tick) begin
          if (tmo_cnt == TMO_LAST) begin
            timeout_set = 1'b1;
            state_nx    = ST_IDLE;
          end else begin
            tmo_cnt_nx = tmo_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_DONE: begin
        // Busy has already been seen high, so a low level is its falling edge.
        if (!tx_busy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= SRC_RSP;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      busy_seen  <= 1'b0;
      tmo_cnt    <= '0;
      tx_timeout <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      tx_data    <= tx_data_nx;
      tx_start   <= tx_start_nx;
      busy_seen  <= busy_seen_nx;
      tmo_cnt    <= tmo_cnt_nx;
      if (timeout_set) tx_timeout <= 1'b1;
      // A pop in the same cycle frees a slot, so only an unpopped full FIFO drops.
      if (rx_valid && fifo_full && !grant_echo) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed corner sequences, a
// FIFO occupancy table and randomized send-order runs against a queue model.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       txclk_tick;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       tx_timeout;

  uart_tx_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .txclk_tick (txclk_tick),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         tick_period, tick_cnt;
  bit         emu_on, emu_rand;
  int         emu_delay, emu_len, emu_phase, emu_cnt;
  logic       prev_start = 1'b0;
  bit         rsp_acc;
  int         rsp_pulses;
  logic [7:0] rsp_q[$];
  logic [7:0] sent_q[$];

  typedef struct {
    int         n_strobes;
    logic [3:0] exp_count;
    logic       exp_ovf;
  } fill_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: advance at the falling edge, then update tick, busy emulator,
  // response source and the launch monitor.
  task automatic step();
    @(negedge clk);
    if (tick_period > 0) begin
      if (tick_cnt >= tick_period - 1) begin
        tick_cnt   = 0;
        txclk_tick = 1'b1;
      end else begin
        tick_cnt++;
        txclk_tick = 1'b0;
      end
    end else begin
      txclk_tick = 1'b0;
    end
    if (emu_on && !reset) begin
      case (emu_phase)
        0: if (prev_start && !tx_start) begin
             emu_cnt   = emu_rand ? int'($urandom_range(1, 3)) : emu_delay;
             emu_phase = 1;
           end
        1: if (emu_cnt <= 1) begin
             tx_busy   = 1'b1;
             emu_cnt   = emu_rand ? int'($urandom_range(4, 20)) : emu_len;
             emu_phase = 2;
           end else emu_cnt--;
        default: if (emu_cnt <= 1) begin
             tx_busy   = 1'b0;
             emu_phase = 0;
           end else emu_cnt--;
      endcase
    end
    if (rsp_acc) begin
      void'(rsp_q.pop_front());
      rsp_acc = 1'b0;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_acc = 1'b1;
      rsp_pulses++;
    end
    rsp_valid = (rsp_q.size() > 0);
    rsp_data  = (rsp_q.size() > 0) ? rsp_q[0] : 8'h00;
    if (tx_start && !prev_start) sent_q.push_back(tx_data);
    prev_start = tx_start;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; txclk_tick = 1'b0;
    tick_period = 0; tick_cnt = 0;
    emu_on = 1'b0; emu_rand = 1'b0; emu_phase = 0; emu_cnt = 0; tx_busy = 1'b0;
    rsp_q.delete(); sent_q.delete(); rsp_acc = 1'b0; rsp_pulses = 0;
    rsp_valid = 1'b0; rsp_data = 8'h00;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    for (int i = 0; i < budget && !tx_start; i++) step();
    check(name, 32'(tx_start), 32'd1);
  endtask

  initial begin
    fill_vec_t fill_tbl[6];
    logic [7:0] echo_m[$];
    logic [7:0] rsp_m[$];
    logic [7:0] exp_q[$];
    int k, m, n, hi, seen;
    bit last_rsp;

    fill_tbl[0] = '{1,  4'd0, 1'b0};
    fill_tbl[1] = '{2,  4'd1, 1'b0};
    fill_tbl[2] = '{5,  4'd4, 1'b0};
    fill_tbl[3] = '{9,  4'd8, 1'b0};
    fill_tbl[4] = '{10, 4'd8, 1'b1};
    fill_tbl[5] = '{11, 4'd8, 1'b1};

    // Reset state, including rsp_ready held low while reset is asserted.
    do_reset();
    reset = 1'b1;
    rsp_q.push_back(8'hAA);
    step(); step();
    check("reset_rsp_ready", 32'(rsp_ready), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_flags", {30'd0, overflow, tx_timeout}, 32'd0);
    do_reset();

    // Single echo with a 16-clk baud tick and a 160-clk busy frame.
    tick_period = 16; emu_on = 1'b1; emu_delay = 3; emu_len = 160;
    push_byte(8'h41);
    check("t1_count_push", 32'(fifo_count), 32'd1);
    step();
    check("t1_count_pop", 32'(fifo_count), 32'd0);
    check("t1_tx_data", 32'(tx_data), 32'h41);
    wait_start("t1_start_seen", 40);
    hi = 0;
    while (tx_start && hi < 100) begin hi++; step(); end
    check("t1_start_width", 32'(hi), 32'd16);
    rsp_q.push_back(8'h5A);
    for (int i = 0; i < 10 && !tx_busy; i++) step();
    for (int i = 0; i < 200 && tx_busy; i++) step();
    check("t1_no_grant_while_busy", 32'(rsp_pulses), 32'd0);
    for (int i = 0; i < 5 && rsp_pulses == 0; i++) step();
    check("t1_idle_after_done", 32'(rsp_pulses), 32'd1);

    // Round-robin with both sources pending from the start.
    do_reset();
    tx_busy = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    rsp_q.push_back(8'hA5);
    step(); step();
    tick_period = 4; emu_on = 1'b1; emu_delay = 2; emu_len = 10; tx_busy = 1'b0;
    for (int i = 0; i < 400 && sent_q.size() < 3; i++) step();
    repeat (50) step();
    check("t2_sent_count", 32'(sent_q.size()), 32'd3);
    if (sent_q.size() >= 3) begin
      check("t2_order0", 32'(sent_q[0]), 32'h11);
      check("t2_order1", 32'(sent_q[1]), 32'hA5);
      check("t2_order2", 32'(sent_q[2]), 32'h22);
    end
    check("t2_rsp_ready_pulses", 32'(rsp_pulses), 32'd1);

    // FIFO fill table: consecutive strobes, no baud tick, FSM parks in ARM.
    foreach (fill_tbl[v]) begin
      do_reset();
      for (int i = 0; i < fill_tbl[v].n_strobes; i++) push_byte(8'(i + 1));
      step();
      check($sformatf("t3_count_n%0d", fill_tbl[v].n_strobes), 32'(fifo_count), 32'(fill_tbl[v].exp_count));
      check($sformatf("t3_ovf_n%0d", fill_tbl[v].n_strobes), 32'(overflow), 32'(fill_tbl[v].exp_ovf));
    end

    // Push and pop together on a full FIFO.
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
    step();
    check("t4_full", 32'(fifo_count), 32'd8);
    tx_busy = 1'b0;
    push_byte(8'hEE);
    check("t4_count_same", 32'(fifo_count), 32'd8);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    check("t4_head_sent", 32'(tx_data), 32'h80);
    push_byte(8'hEF);
    check("t4_ovf_when_no_pop", 32'(overflow), 32'd1);

    // Busy never rises: timeout after BUSY_TMO ticks past HOLD, then next byte.
    do_reset();
    tick_period = 4;
    push_byte(8'h33);
    push_byte(8'h44);
    wait_start("t5_start1", 20);
    check("t5_byte1", 32'(tx_data), 32'h33);
    for (int i = 0; i < 20 && tx_start; i++) step();
    check("t5_no_early_timeout", 32'(tx_timeout), 32'd0);
    n = 0;
    while (!tx_timeout && n < 40) begin step(); n++; end
    check("t5_timeout_cycles", 32'(n), 32'd16);
    wait_start("t5_start2", 30);
    check("t5_byte2", 32'(tx_data), 32'h44);
    check("t5_timeout_sticky", 32'(tx_timeout), 32'd1);

    // Reset while tx_start is held.
    do_reset();
    tick_period = 16;
    push_byte(8'h77);
    push_byte(8'h78);
    wait_start("t6_start", 40);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("t6_start_cleared", 32'(tx_start), 32'd0);
    check("t6_fifo_emptied", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin step(); if (tx_start) seen++; end
    check("t6_quiet_after_reset", 32'(seen), 32'd0);
    push_byte(8'h99);
    wait_start("t6_restart", 40);
    check("t6_new_byte", 32'(tx_data), 32'h99);

    // Randomized preload of both sources; send order predicted from the rules.
    for (int s = 0; s < 6; s++) begin
      do_reset();
      echo_m.delete(); rsp_m.delete(); exp_q.delete();
      tx_busy = 1'b1;
      k = int'($urandom_range(1, 8));
      m = int'($urandom_range(0, 4));
      for (int i = 0; i < k; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        echo_m.push_back(b);
        push_byte(b);
      end
      for (int j = 0; j < m; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        rsp_m.push_back(b);
        rsp_q.push_back(b);
      end
      step(); step();
      tick_period = 4; emu_on = 1'b1; emu_rand = 1'b1; tx_busy = 1'b0;
      last_rsp = 1'b1;
      while (echo_m.size() > 0 || rsp_m.size() > 0) begin
        if (echo_m.size() > 0 && (rsp_m.size() == 0 || last_rsp)) begin
          exp_q.push_back(echo_m.pop_front());
          last_rsp = 1'b0;
        end else begin
          exp_q.push_back(rsp_m.pop_front());
          last_rsp = 1'b1;
        end
      end
      for (int i = 0; i < 2500 && sent_q.size() < k + m; i++) step();
      repeat (40) step();
      check($sformatf("rnd%0d_sent_count", s), 32'(sent_q.size()), 32'(k + m));
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
        check($sformatf("rnd%0d_byte%0d", s, i), 32'(sent_q[i]), 32'(exp_q[i]));
      check($sformatf("rnd%0d_rsp_pulses", s), 32'(rsp_pulses), 32'(m));
      check($sformatf("rnd%0d_drained", s), 32'(fifo_count), 32'd0);
      check($sformatf("rnd%0d_flags", s), {30'd0, overflow, tx_timeout}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
